// File: rtl/sync_fifo_pkg.sv
// Shared types and default sizing for the sync_fifo_ext family.
// Build option: define SYNC_FIFO_ERR_EN to add the sticky overflow/underflow flags.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// The array carries no reset, so it can map onto distributed RAM.
module sync_fifo_ram #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, occupancy and threshold flags.
// Build option: define SYNC_FIFO_ERR_EN to add the sticky overflow/underflow flags.
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter  int         DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int         DEPTH      = DEF_DEPTH,
  parameter  int         AF_THRESH  = DEPTH - 2,
  parameter  int         AE_THRESH  = 2,
  parameter  fifo_mode_e MODE       = FIFO_STD,
  localparam int         ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL   = (ADDR_WIDTH + 1)'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_ext: DEPTH (%0d) must be a power of two >= 2", DEPTH);
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_ext: AF_THRESH (%0d) out of range 1..DEPTH", AF_THRESH);
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_ext: AE_THRESH (%0d) out of range 0..DEPTH-1", AE_THRESH);
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wr_accept;
  logic                  rd_accept;

  // Flags come straight from the registered count, so they never glitch within a cycle.
  assign count        = count_reg;
  assign full         = (count_reg == FULL_LVL);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_LVL);
  assign almost_empty = (count_reg <= AE_LVL);

  assign wr_accept = wr_en && !full && !flush;
  assign rd_accept = rd_en && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
      case ({wr_accept, rd_accept})
        2'b10:   count_reg <= count_reg + (ADDR_WIDTH + 1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_WIDTH + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (wdata),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head word is shown combinationally; zero when nothing is stored.
    assign rdata = empty ? '0 : ram_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            rdata_reg <= '0;
      else if (flush)     rdata_reg <= '0;
      else if (rd_accept) rdata_reg <= ram_rdata;
    end
    assign rdata = rdata_reg;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en && full)  overflow_reg  <= 1'b1;
      if (rd_en && empty) underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Self-checking bench: one STD and one FWFT instance share stimulus and are compared
// every cycle against a queue-based model; literal checks pin the model on key scenarios.
module tb_sync_fifo_ext;
  import sync_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_en = 1'b0;

  logic [7:0] s_rdata, f_rdata;
  logic       s_full, f_full, s_empty, f_empty, s_af, f_af, s_ae, f_ae;
  logic [4:0] s_count, f_count;
  logic       s_ovf, f_ovf, s_udf, f_udf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .MODE(FIFO_STD)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(s_rdata), .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf));

  sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .MODE(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(f_rdata), .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf));

  // Behavioural model: contents as a queue, STD output word, sticky error bits.
  logic [7:0] mq[$];
  logic [7:0] m_std_rdata = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_std_rdata = 8'h00;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_std_rdata = 8'h00;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      automatic bit was_full  = (mq.size() == 16);
      automatic bit was_empty = (mq.size() == 0);
      if (rd_en && !was_empty) m_std_rdata = mq.pop_front();
      if (wr_en && !was_full) mq.push_back(wdata);
`ifdef SYNC_FIFO_ERR_EN
      if (wr_en && was_full)  m_ovf = 1'b1;
      if (rd_en && was_empty) m_udf = 1'b1;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      automatic int n = mq.size();
      automatic logic [7:0] head = (n > 0) ? mq[0] : 8'h00;
      chk("std_count", 32'(s_count), 32'(n));
      chk("fwft_count", 32'(f_count), 32'(n));
      chk("std_empty", 32'(s_empty), 32'(n == 0));
      chk("fwft_empty", 32'(f_empty), 32'(n == 0));
      chk("std_full", 32'(s_full), 32'(n == 16));
      chk("fwft_full", 32'(f_full), 32'(n == 16));
      chk("std_af", 32'(s_af), 32'(n >= 14));
      chk("fwft_af", 32'(f_af), 32'(n >= 14));
      chk("std_ae", 32'(s_ae), 32'(n <= 2));
      chk("fwft_ae", 32'(f_ae), 32'(n <= 2));
      chk("std_rdata", 32'(s_rdata), 32'(m_std_rdata));
      chk("fwft_rdata", 32'(f_rdata), 32'(head));
      chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
      chk("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
      chk("std_udf", 32'(s_udf), 32'(m_udf));
      chk("fwft_udf", 32'(f_udf), 32'(m_udf));
      $display("cycle t=%0t wr=%0b wd=%02h rd=%0b fl=%0b n=%0d std=%02h fwft=%02h",
               $time, wr_en, wdata, rd_en, flush, n, s_rdata, f_rdata);
    end
  end

  // Applies one cycle of inputs at negedge+1 and returns at the following negedge+1.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr_en = w; wdata = d; rd_en = r; flush = f;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_std_rdata"}, 32'(s_rdata), 32'h0);
    chk({tag, "_fwft_rdata"}, 32'(f_rdata), 32'h0);
    chk({tag, "_count"}, 32'(s_count), 32'h0);
    chk({tag, "_fcount"}, 32'(f_count), 32'h0);
    chk({tag, "_empty"}, 32'(s_empty & f_empty), 32'h1);
    chk({tag, "_ae"}, 32'(s_ae & f_ae), 32'h1);
    chk({tag, "_full"}, 32'(s_full | f_full), 32'h0);
    chk({tag, "_af"}, 32'(s_af | f_af), 32'h0);
    chk({tag, "_err"}, 32'(s_ovf | s_udf | f_ovf | f_udf), 32'h0);
  endtask

  localparam logic EXP_ERR =
`ifdef SYNC_FIFO_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk_reset_state("rst_hold");
    rst = 1'b0;
    cycle(0, 8'h00, 0, 0);
    chk_reset_state("idle");

    // STD fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 8'(i), 0, 0);
      if (i == 13) chk("af_at13", 32'(s_af), 32'h0);
      if (i == 14) chk("af_at14", 32'(s_af), 32'h1);
    end
    chk("fill_full", 32'(s_full), 32'h1);
    chk("fill_count", 32'(s_count), 32'd16);
    chk("fill_fwft_head", 32'(f_rdata), 32'h01);

    // Write while full: dropped, overflow if enabled
    cycle(1, 8'hEE, 0, 0);
    chk("ovf_count", 32'(s_count), 32'd16);
    chk("ovf_flag", 32'(s_ovf), 32'(EXP_ERR));
    chk("ovf_flag_fwft", 32'(f_ovf), 32'(EXP_ERR));

    // Drain 16 in order, 1-cycle STD latency
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 8'h00, 1, 0);
      chk("std_order", 32'(s_rdata), 32'(i));
    end
    chk("drain_empty", 32'(s_empty), 32'h1);
    chk("drain_fwft_rdata", 32'(f_rdata), 32'h0);

    // Read while empty: underflow if enabled, STD rdata holds
    cycle(0, 8'h00, 1, 0);
    chk("udf_flag", 32'(s_udf), 32'(EXP_ERR));
    chk("udf_hold", 32'(s_rdata), 32'h10);

    cycle(0, 8'h00, 0, 1);
    chk("flush_errs", 32'(s_ovf | s_udf | f_ovf | f_udf), 32'h0);
    chk("flush_count", 32'(s_count), 32'h0);
    chk("flush_std_rdata", 32'(s_rdata), 32'h0);

    // FWFT single word
    cycle(1, 8'hA5, 0, 0);
    chk("fwft_a5", 32'(f_rdata), 32'hA5);
    chk("fwft_a5_empty", 32'(f_empty), 32'h0);
    cycle(0, 8'h00, 1, 0);
    chk("fwft_pop", 32'(f_rdata), 32'h0);
    chk("fwft_pop_empty", 32'(f_empty), 32'h1);
    chk("std_a5", 32'(s_rdata), 32'hA5);

    // Fill to 8 then 40 simultaneous cycles across the wrap
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 8'(8'h48 + i), 1, 0);
      chk("wrap_std", 32'(s_rdata), 32'(8'h40 + i));
    end
    chk("wrap_count", 32'(s_count), 32'd8);

    // Flush racing with wr+rd at count 5
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
    chk("pre_flush_count", 32'(s_count), 32'd5);
    cycle(1, 8'h77, 1, 1);
    chk("flush_rw_count", 32'(f_count), 32'h0);
    chk("flush_rw_empty", 32'(f_empty), 32'h1);
    cycle(1, 8'h3C, 0, 0);
    chk("post_flush_head", 32'(f_rdata), 32'h3C);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3);
    end

    // Asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) cycle(1, 8'($urandom), i[0], 0);
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    @(negedge clk); #1;
    rst = 1'b0;
    cycle(0, 8'h00, 0, 0);
    chk_reset_state("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
